// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: shared ISA constants for the CR16-style core.
// Opcode/opext/cond codes, FSM state enum and IR field positions.
package cpu_isa_pkg;

    // Primary opcodes (IR[15:12])
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // R-type extensions (IR[7:4]); these share encodings with
    // the immediate-form opcodes above.
    localparam logic [3:0] EXT_AND = 4'b0001;
    localparam logic [3:0] EXT_OR  = 4'b0010;
    localparam logic [3:0] EXT_XOR = 4'b0011;
    localparam logic [3:0] EXT_ADD = 4'b0101;
    localparam logic [3:0] EXT_SUB = 4'b1001;
    localparam logic [3:0] EXT_CMP = 4'b1011;
    localparam logic [3:0] EXT_MOV = 4'b1101;

    // Branch conditions (IR[11:8])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_UC = 4'b1110;

    // IR field low-bit positions
    localparam int OPC_LO  = 12;
    localparam int RDST_LO = 8;
    localparam int EXT_LO  = 4;
    localparam int RSRC_LO = 0;
    localparam int IMM_LO  = 0;
    localparam int IMM_W   = 8;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

endpackage

// File: rtl/cpu_fetch_decode_imm_extend.sv
// imm_extend: widen an 8-bit immediate to WIDTH bits.
// Ports: imm8 (in), sign_ext (in, 1=sign 0=zero), imm (out).
module imm_extend
    import cpu_isa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [IMM_W-1:0] imm8,
    input  logic             sign_ext,
    output logic [WIDTH-1:0] imm
);

    logic fill;

    assign fill = sign_ext & imm8[IMM_W-1];
    assign imm  = {{(WIDTH-IMM_W){fill}}, imm8};

endmodule

// File: rtl/cpu_fetch_decode.sv
// cpu_fetch_decode: multi-cycle fetch/decode/branch controller.
// Ports: clk, rst_n, mem_* fetch port, flag_z in; decoded
// fields, write strobes, imm, pc and halted out.
module cpu_fetch_decode
    import cpu_isa_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   mem_rdata,
    input  logic               mem_ready,
    input  logic               flag_z,
    output logic [WIDTH-1:0]   mem_addr,
    output logic               mem_rd_en,
    output logic [3:0]         opcode,
    output logic [3:0]         opext,
    output logic [REGBITS-1:0] ra1,
    output logic [REGBITS-1:0] ra2,
    output logic [REGBITS-1:0] wa,
    output logic               regwrite,
    output logic               flag_we,
    output logic               imm_sel,
    output logic [WIDTH-1:0]   imm,
    output logic [WIDTH-1:0]   pc,
    output logic               halted
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_inc;
    logic [3:0]       alu_key;
    logic [3:0]       cond;
    logic             alu_valid;
    logic             alu_cmp;
    logic             alu_signed;
    logic             is_branch;
    logic             is_halt;
    logic             taken;
    logic             imm_signed;

    // Field slicing
    assign opcode = ir[OPC_LO +: 4];
    assign opext  = ir[EXT_LO +: 4];
    assign ra1    = ir[RDST_LO +: REGBITS];
    assign ra2    = ir[RSRC_LO +: REGBITS];
    assign wa     = ir[RDST_LO +: REGBITS];
    assign cond   = ir[RDST_LO +: 4];

    assign is_branch = (opcode == OP_BCOND);
    assign is_halt   = (opcode == OP_HALT);

    // R-type selects the operation by opext; immediate forms
    // reuse the same codes as their opcode.
    assign alu_key = (opcode == OP_RTYPE) ? opext : opcode;

    always_comb begin
        alu_valid  = 1'b0;
        alu_cmp    = 1'b0;
        alu_signed = 1'b0;
        unique case (alu_key)
            EXT_AND, EXT_OR, EXT_XOR, EXT_MOV: begin
                alu_valid = 1'b1;
            end
            EXT_ADD, EXT_SUB: begin
                alu_valid  = 1'b1;
                alu_signed = 1'b1;
            end
            EXT_CMP: begin
                alu_valid  = 1'b1;
                alu_cmp    = 1'b1;
                alu_signed = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm_sel    = alu_valid & (opcode != OP_RTYPE);
    assign imm_signed = alu_signed | is_branch;

    // Branch offsets share the sign-extender with ADDI/SUBI/CMPI
    imm_extend #(
        .WIDTH(WIDTH)
    ) u_imm_extend (
        .imm8    (ir[IMM_LO +: IMM_W]),
        .sign_ext(imm_signed),
        .imm     (imm)
    );

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_EQ: taken = flag_z;
            COND_NE: taken = ~flag_z;
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign pc_inc  = pc + {{(WIDTH-1){1'b0}}, 1'b1};
    assign pc_next = (is_branch && taken) ? pc + imm : pc_inc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_FETCH:   if (mem_ready) state_next = ST_DECODE;
            ST_DECODE:  state_next = ST_EXECUTE;
            ST_EXECUTE: state_next = is_halt ? ST_HALT : ST_FETCH;
            ST_HALT:    state_next = ST_HALT;
            default:    state_next = ST_FETCH;
        endcase
    end

    // Output logic; the fetch request is gated by rst_n so it
    // drops the instant reset is asserted.
    always_comb begin
        mem_rd_en = 1'b0;
        regwrite  = 1'b0;
        flag_we   = 1'b0;
        halted    = 1'b0;
        unique case (state)
            ST_FETCH:   mem_rd_en = rst_n;
            ST_EXECUTE: begin
                regwrite = alu_valid & ~alu_cmp;
                flag_we  = alu_valid & alu_cmp;
            end
            ST_HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr = pc;

    // Instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (state == ST_FETCH && mem_ready) begin
            ir <= mem_rdata;
        end
    end

    // Program counter: updates only leaving EXECUTE, never on HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (state == ST_EXECUTE && !is_halt) begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// tb_cpu_fetch_decode: directed test of the fetch/decode FSM.
// Memory is a bench-side array read combinationally at mem_addr.
module tb_cpu_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        flag_z;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [3:0]  opcode;
    logic [3:0]  opext;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa;
    logic        regwrite;
    logic        flag_we;
    logic        imm_sel;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        halted;

    logic [15:0] mem [0:65535];
    int n_cmp;
    int n_bad;

    cpu_fetch_decode #(
        .WIDTH(16),
        .REGBITS(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .flag_z   (flag_z),
        .mem_addr (mem_addr),
        .mem_rd_en(mem_rd_en),
        .opcode   (opcode),
        .opext    (opext),
        .ra1      (ra1),
        .ra2      (ra2),
        .wa       (wa),
        .regwrite (regwrite),
        .flag_we  (flag_we),
        .imm_sel  (imm_sel),
        .imm      (imm),
        .pc       (pc),
        .halted   (halted)
    );

    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run3();
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        mem[0] = 16'h0351;
        mem_ready = 1'b1;
        flag_z = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL rst_pc got %h want 0000", pc); end
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_rd_en got %b want 0", mem_rd_en); end
        n_cmp++; if ({regwrite, flag_we, imm_sel, halted} !== 4'b0000) begin n_bad++; $display("FAIL rst_strobes got %b want 0000", {regwrite, flag_we, imm_sel, halted}); end
        n_cmp++; if (opcode !== 4'h0 || ra1 !== 4'h0) begin n_bad++; $display("FAIL rst_ir got op=%h ra1=%h want 0,0", opcode, ra1); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0000) begin n_bad++; $display("FAIL rel_fetch got en=%b addr=%h want 1,0000", mem_rd_en, mem_addr); end
    endtask

    task automatic test_rtype();
        step();
        n_cmp++; if (ra1 !== 4'd3 || ra2 !== 4'd1) begin n_bad++; $display("FAIL add_fields got ra1=%h ra2=%h want 3,1", ra1, ra2); end
        n_cmp++; if (regwrite !== 1'b0 || mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL add_decode got rw=%b en=%b want 0,0", regwrite, mem_rd_en); end
        mem_ready = 1'b0;
        step();
        n_cmp++; if (regwrite !== 1'b1 || wa !== 4'd3 || imm_sel !== 1'b0 || flag_we !== 1'b0) begin n_bad++; $display("FAIL add_exec got rw=%b wa=%h isel=%b fwe=%b want 1,3,0,0", regwrite, wa, imm_sel, flag_we); end
        step();
        n_cmp++; if (regwrite !== 1'b0 || pc !== 16'h0001 || mem_rd_en !== 1'b1) begin n_bad++; $display("FAIL add_next got rw=%b pc=%h en=%b want 0,0001,1", regwrite, pc, mem_rd_en); end
    endtask

    task automatic test_wait_imm();
        mem[1] = 16'h52FF;
        mem[2] = 16'h12FF;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (mem_addr !== 16'h0001 || mem_rd_en !== 1'b1 || ra1 !== 4'd3) begin n_bad++; $display("FAIL wait_hold got addr=%h en=%b ra1=%h want 0001,1,3", mem_addr, mem_rd_en, ra1); end
        end
        mem_ready = 1'b1;
        step();
        n_cmp++; if (imm !== 16'hFFFF || imm_sel !== 1'b1) begin n_bad++; $display("FAIL addi_imm got imm=%h isel=%b want ffff,1", imm, imm_sel); end
        step();
        n_cmp++; if (regwrite !== 1'b1 || wa !== 4'd2) begin n_bad++; $display("FAIL addi_exec got rw=%b wa=%h want 1,2", regwrite, wa); end
        step();
        n_cmp++; if (pc !== 16'h0002) begin n_bad++; $display("FAIL addi_pc got %h want 0002", pc); end
        step();
        n_cmp++; if (imm !== 16'h00FF || imm_sel !== 1'b1) begin n_bad++; $display("FAIL andi_imm got imm=%h isel=%b want 00ff,1", imm, imm_sel); end
        step();
        n_cmp++; if (regwrite !== 1'b1) begin n_bad++; $display("FAIL andi_exec got rw=%b want 1", regwrite); end
        step();
        n_cmp++; if (pc !== 16'h0003) begin n_bad++; $display("FAIL andi_pc got %h want 0003", pc); end
    endtask

    task automatic test_cmp();
        mem[3] = 16'h04B5;
        step();
        n_cmp++; if (flag_we !== 1'b0) begin n_bad++; $display("FAIL cmp_decode got fwe=%b want 0", flag_we); end
        step();
        n_cmp++; if (flag_we !== 1'b1 || regwrite !== 1'b0 || imm_sel !== 1'b0) begin n_bad++; $display("FAIL cmp_exec got fwe=%b rw=%b isel=%b want 1,0,0", flag_we, regwrite, imm_sel); end
        step();
        n_cmp++; if (flag_we !== 1'b0 || pc !== 16'h0004) begin n_bad++; $display("FAIL cmp_next got fwe=%b pc=%h want 0,0004", flag_we, pc); end
    endtask

    task automatic test_branch();
        mem[4] = 16'hCE0C;
        run3();
        n_cmp++; if (pc !== 16'h0010) begin n_bad++; $display("FAIL uc_fwd got %h want 0010", pc); end
        mem[16'h10] = 16'hC0FC;
        flag_z = 1'b1;
        run3();
        n_cmp++; if (pc !== 16'h000C) begin n_bad++; $display("FAIL beq_taken got %h want 000c", pc); end
        mem[16'h0C] = 16'hCE04;
        run3();
        n_cmp++; if (pc !== 16'h0010) begin n_bad++; $display("FAIL uc_back got %h want 0010", pc); end
        flag_z = 1'b0;
        run3();
        n_cmp++; if (pc !== 16'h0011) begin n_bad++; $display("FAIL beq_not got %h want 0011", pc); end
        mem[16'h11] = 16'hCEFF;
        run3();
        n_cmp++; if (pc !== 16'h0010) begin n_bad++; $display("FAIL uc_m1 got %h want 0010", pc); end
        mem[16'h10] = 16'hCE02;
        run3();
        n_cmp++; if (pc !== 16'h0012) begin n_bad++; $display("FAIL uc_p2 got %h want 0012", pc); end
    endtask

    task automatic test_wrap();
        mem[16'h12] = 16'hCEF3;
        run3();
        n_cmp++; if (pc !== 16'h0005) begin n_bad++; $display("FAIL uc_m13 got %h want 0005", pc); end
        mem[16'h05] = 16'hCE80;
        run3();
        n_cmp++; if (pc !== 16'hFF85) begin n_bad++; $display("FAIL br_wrap got %h want ff85", pc); end
        mem[16'hFF85] = 16'hCE7A;
        run3();
        n_cmp++; if (pc !== 16'hFFFF) begin n_bad++; $display("FAIL br_top got %h want ffff", pc); end
        mem[16'hFFFF] = 16'h7000;
        step();
        step();
        n_cmp++; if (regwrite !== 1'b0 || flag_we !== 1'b0) begin n_bad++; $display("FAIL nop_exec got rw=%b fwe=%b want 0,0", regwrite, flag_we); end
        step();
        n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL pc_wrap got %h want 0000", pc); end
    endtask

    task automatic test_halt();
        mem[0] = 16'hF000;
        step();
        step();
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_early got %b want 0", halted); end
        step();
        n_cmp++; if (halted !== 1'b1 || pc !== 16'h0000) begin n_bad++; $display("FAIL halt_enter got h=%b pc=%h want 1,0000", halted, pc); end
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++; if (mem_rd_en !== 1'b0 || halted !== 1'b1 || regwrite !== 1'b0 || flag_we !== 1'b0) begin n_bad++; $display("FAIL halt_hold got en=%b h=%b rw=%b fwe=%b want 0,1,0,0", mem_rd_en, halted, regwrite, flag_we); end
        end
        n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL halt_pc got %h want 0000", pc); end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_unhalt got %b want 0", halted); end
        mem[0] = 16'h0351;
        mem_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        n_cmp++; if (mem_rd_en !== 1'b1) begin n_bad++; $display("FAIL mid_fetch got en=%b want 1", mem_rd_en); end
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_drop got en=%b want 0", mem_rd_en); end
        step();
        n_cmp++; if (ra1 !== 4'd0 || opext !== 4'd0) begin n_bad++; $display("FAIL rst_discard got ra1=%h ext=%h want 0,0", ra1, opext); end
        mem[0] = 16'h04B5;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (pc !== 16'h0000 || mem_rd_en !== 1'b1) begin n_bad++; $display("FAIL rst_rel got pc=%h en=%b want 0000,1", pc, mem_rd_en); end
        step();
        step();
        n_cmp++; if (flag_we !== 1'b1 || regwrite !== 1'b0) begin n_bad++; $display("FAIL post_cmp got fwe=%b rw=%b want 1,0", flag_we, regwrite); end
        step();
        n_cmp++; if (pc !== 16'h0001) begin n_bad++; $display("FAIL post_pc got %h want 0001", pc); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'h7000;
        rst_n = 1'b0;
        mem_ready = 1'b0;
        flag_z = 1'b0;
        #2;
        test_reset();
        test_rtype();
        test_wait_imm();
        test_cmp();
        test_branch();
        test_wrap();
        test_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
